// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions/interrupts/MRET, saves trap CSRs,
// rewrites mstatus and redirects the core. Optional TRAP_VECTORED_EN enables vectored interrupts.
module trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            done,
  input  logic            exc_valid,
  input  logic [4:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_badaddr,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] next_pc,
  input  logic            sw_irq,
  input  logic            time_compare,
  input  logic            ext_irq,
  input  logic [XLEN-1:0] mstatus_in,
  input  logic [XLEN-1:0] mie_in,
  input  logic [XLEN-1:0] mtvec_in,
  output logic [XLEN-1:0] mip,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mbadaddr,
  output logic [XLEN-1:0] mepc,
  output logic            mstatus_we,
  output logic [XLEN-1:0] mstatus_wdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            stall
);

  typedef enum logic [2:0] {
    IDLE, SAVE, STATUS, JUMP, RET_STATUS, RET_JUMP
  } state_t;

  state_t          state;
  logic [XLEN-1:0] mip_next;
  logic [XLEN-1:0] irq_pend;
  logic            irq_take;
  logic [4:0]      irq_code;
  logic [XLEN-1:0] trap_status;
  logic [XLEN-1:0] ret_status;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] trap_target;

  always_comb begin
    mip_next     = '0;
    mip_next[3]  = sw_irq;
    mip_next[7]  = time_compare;
    mip_next[11] = ext_irq;

    // mip only ever carries bits 3/7/11, so any set bit here is a real pending source
    irq_pend = mip & mie_in;
    irq_take = mstatus_in[3] && done && (|irq_pend);
    if (irq_pend[11])     irq_code = 5'd11;
    else if (irq_pend[3]) irq_code = 5'd3;
    else                  irq_code = 5'd7;

    trap_status        = mstatus_in;
    trap_status[7]     = mstatus_in[3];
    trap_status[3]     = 1'b0;
    trap_status[12:11] = 2'b11;

    ret_status         = mstatus_in;
    ret_status[3]      = mstatus_in[7];
    ret_status[7]      = 1'b1;
    ret_status[12:11]  = 2'b11;

    base        = mtvec_in & ~XLEN'(3);
    trap_target = base;
`ifdef TRAP_VECTORED_EN
    // mcause is already latched here; its top bit marks the trap as an interrupt
    if (mtvec_in[1:0] == 2'b01 && mcause[XLEN-1])
      trap_target = base + {{(XLEN-7){1'b0}}, mcause[4:0], 2'b00};
`endif
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state          <= IDLE;
      mip            <= '0;
      mcause         <= '0;
      mbadaddr       <= '0;
      mepc           <= '0;
      mstatus_we     <= 1'b0;
      mstatus_wdata  <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      stall          <= 1'b0;
    end else begin
      mip            <= mip_next;
      mstatus_we     <= 1'b0;
      redirect_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (exc_valid) begin
            mepc     <= exc_pc;
            mcause   <= {{(XLEN-5){1'b0}}, exc_cause};
            mbadaddr <= exc_badaddr;
            state    <= SAVE;
            stall    <= 1'b1;
          end else if (irq_take) begin
            mepc     <= next_pc;
            mcause   <= {1'b1, {(XLEN-6){1'b0}}, irq_code};
            mbadaddr <= '0;
            state    <= SAVE;
            stall    <= 1'b1;
          end else if (mret_valid) begin
            mstatus_we    <= 1'b1;
            mstatus_wdata <= ret_status;
            state         <= RET_STATUS;
            stall         <= 1'b1;
          end
        end
        SAVE: begin
          mstatus_we    <= 1'b1;
          mstatus_wdata <= trap_status;
          state         <= STATUS;
        end
        STATUS: begin
          redirect_valid <= 1'b1;
          redirect_pc    <= trap_target;
          state          <= JUMP;
        end
        JUMP: begin
          state <= IDLE;
          stall <= 1'b0;
        end
        RET_STATUS: begin
          redirect_valid <= 1'b1;
          redirect_pc    <= mepc;
          state          <= RET_JUMP;
        end
        RET_JUMP: begin
          state <= IDLE;
          stall <= 1'b0;
        end
        default: begin
          state <= IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: expected trap/MRET sequences queued at stimulus, checked cycle by cycle.
module tb_trap_ctrl;
  localparam int XLEN = 32;
`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] VEC_PC = 32'h0000_081C;
`else
  localparam logic [31:0] VEC_PC = 32'h0000_0800;
`endif

  logic            clk = 1'b0;
  logic            resetn, done, exc_valid, mret_valid;
  logic [4:0]      exc_cause;
  logic [XLEN-1:0] exc_pc, exc_badaddr, next_pc;
  logic            sw_irq, time_compare, ext_irq;
  logic [XLEN-1:0] mstatus_in, mie_in, mtvec_in;
  logic [XLEN-1:0] mip, mcause, mbadaddr, mepc, mstatus_wdata, redirect_pc;
  logic            mstatus_we, redirect_valid, stall;

  trap_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .resetn(resetn), .done(done), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_badaddr(exc_badaddr),
    .mret_valid(mret_valid), .next_pc(next_pc), .sw_irq(sw_irq),
    .time_compare(time_compare), .ext_irq(ext_irq), .mstatus_in(mstatus_in),
    .mie_in(mie_in), .mtvec_in(mtvec_in), .mip(mip), .mcause(mcause),
    .mbadaddr(mbadaddr), .mepc(mepc), .mstatus_we(mstatus_we),
    .mstatus_wdata(mstatus_wdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          is_ret;
    logic [31:0] mepc, mcause, mbad, wdata, rpc;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic clear_req();
    exc_valid    = 1'b0;
    done         = 1'b0;
    mret_valid   = 1'b0;
    sw_irq       = 1'b0;
    time_compare = 1'b0;
    ext_irq      = 1'b0;
  endtask

  task automatic push(input string tag, input bit is_ret, input logic [31:0] pc,
                      input logic [31:0] cause, input logic [31:0] bad,
                      input logic [31:0] wdata, input logic [31:0] rpc);
    exp_t e;
    e.tag = tag; e.is_ret = is_ret; e.mepc = pc; e.mcause = cause;
    e.mbad = bad; e.wdata = wdata; e.rpc = rpc;
    sb.push_back(e);
  endtask

  // Request is held by the caller during the accept cycle; this walks the following cycles.
  task automatic run_seq();
    exp_t e;
    if (sb.size() == 0) begin
      chk1("scoreboard_empty", 1'b1, 1'b0);
      return;
    end
    e = sb.pop_front();
    @(negedge clk);
    clear_req();
    chk1({e.tag, ".c1_stall"}, stall, 1'b1);
    if (!e.is_ret) begin
      chk({e.tag, ".mepc"}, mepc, e.mepc);
      chk({e.tag, ".mcause"}, mcause, e.mcause);
      chk({e.tag, ".mbadaddr"}, mbadaddr, e.mbad);
      chk1({e.tag, ".c1_we"}, mstatus_we, 1'b0);
      @(negedge clk);
      chk1({e.tag, ".c2_stall"}, stall, 1'b1);
      chk1({e.tag, ".c2_we"}, mstatus_we, 1'b1);
      chk({e.tag, ".wdata"}, mstatus_wdata, e.wdata);
      chk1({e.tag, ".c2_rv"}, redirect_valid, 1'b0);
      @(negedge clk);
      chk1({e.tag, ".c3_stall"}, stall, 1'b1);
      chk1({e.tag, ".c3_we"}, mstatus_we, 1'b0);
    end else begin
      chk1({e.tag, ".c1_we"}, mstatus_we, 1'b1);
      chk({e.tag, ".wdata"}, mstatus_wdata, e.wdata);
      chk1({e.tag, ".c1_rv"}, redirect_valid, 1'b0);
      @(negedge clk);
      chk1({e.tag, ".c2_stall"}, stall, 1'b1);
      chk({e.tag, ".mepc_kept"}, mepc, e.mepc);
      chk({e.tag, ".mcause_kept"}, mcause, e.mcause);
      chk({e.tag, ".mbad_kept"}, mbadaddr, e.mbad);
    end
    chk1({e.tag, ".rv"}, redirect_valid, 1'b1);
    chk({e.tag, ".rpc"}, redirect_pc, e.rpc);
    @(negedge clk);
    chk1({e.tag, ".end_stall"}, stall, 1'b0);
    chk1({e.tag, ".end_rv"}, redirect_valid, 1'b0);
  endtask

  task automatic no_trap(input string tag, input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk1({tag, ".stall"}, stall, 1'b0);
      chk1({tag, ".rv"}, redirect_valid, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b1;
    clear_req();
    exc_cause = '0; exc_pc = '0; exc_badaddr = '0; next_pc = '0;
    mstatus_in = '0; mie_in = '0; mtvec_in = '0;
    repeat (2) @(negedge clk);
    chk("rst.mip", mip, 32'h0);
    chk("rst.mcause", mcause, 32'h0);
    chk("rst.mepc", mepc, 32'h0);
    chk("rst.mbadaddr", mbadaddr, 32'h0);
    chk1("rst.we", mstatus_we, 1'b0);
    chk1("rst.rv", redirect_valid, 1'b0);
    chk1("rst.stall", stall, 1'b0);
    resetn = 1'b0;

    // Exception with MIE=1: MPIE takes old MIE, MPP=11
    @(negedge clk);
    mtvec_in = 32'h800; mstatus_in = 32'h8;
    exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h100; exc_badaddr = 32'hDEAD;
    push("exc", 1'b0, 32'h100, 32'h2, 32'hDEAD, 32'h1880, 32'h800);
    run_seq();

    // MEI beats MTI
    @(negedge clk);
    mie_in = 32'h888; ext_irq = 1'b1; time_compare = 1'b1; next_pc = 32'h204;
    @(negedge clk);
    chk("irq.mip", mip, 32'h880);
    done = 1'b1;
    push("irq_prio", 1'b0, 32'h204, 32'h8000_000B, 32'h0, 32'h1880, 32'h800);
    run_seq();

    // Globally masked: nothing taken, saved CSRs untouched
    @(negedge clk);
    mstatus_in = 32'h0; ext_irq = 1'b1; time_compare = 1'b1;
    @(negedge clk);
    done = 1'b1;
    no_trap("masked", 3);
    chk("masked.mcause", mcause, 32'h8000_000B);
    clear_req();

    // Pending and enabled but no retirement
    mstatus_in = 32'h8; sw_irq = 1'b1;
    @(negedge clk);
    chk("nodone.mip", mip, 32'h008);
    no_trap("nodone", 3);

    // Exception wins over a simultaneous interrupt
    done = 1'b1; exc_valid = 1'b1; exc_cause = 5'd5; exc_pc = 32'h300; exc_badaddr = 32'h44;
    push("exc_vs_irq", 1'b0, 32'h300, 32'h5, 32'h44, 32'h1880, 32'h800);
    run_seq();

    // MRET back to saved mepc
    @(negedge clk);
    mstatus_in = 32'h1880; mret_valid = 1'b1;
    push("mret", 1'b1, 32'h300, 32'h5, 32'h44, 32'h1888, 32'h300);
    run_seq();

    // Timer interrupt with mtvec in vectored mode
    @(negedge clk);
    mstatus_in = 32'h8; mtvec_in = 32'h801; time_compare = 1'b1; next_pc = 32'h400;
    @(negedge clk);
    done = 1'b1;
    push("vec_irq", 1'b0, 32'h400, 32'h8000_0007, 32'h0, 32'h1880, VEC_PC);
    run_seq();

    @(negedge clk);
    exc_valid = 1'b1; exc_cause = 5'd3; exc_pc = 32'h500; exc_badaddr = 32'h0;
    push("vec_exc", 1'b0, 32'h500, 32'h3, 32'h0, 32'h1880, 32'h800);
    run_seq();

    // Reset while in STATUS
    @(negedge clk);
    mtvec_in = 32'h800;
    exc_valid = 1'b1; exc_cause = 5'd1; exc_pc = 32'h600; exc_badaddr = 32'h11;
    @(negedge clk);
    clear_req();
    chk1("midrst.c1_stall", stall, 1'b1);
    @(negedge clk);
    chk1("midrst.in_status", mstatus_we, 1'b1);
    #2 resetn = 1'b1;
    #1;
    chk1("midrst.we", mstatus_we, 1'b0);
    chk1("midrst.stall", stall, 1'b0);
    chk("midrst.mepc", mepc, 32'h0);
    chk("midrst.mcause", mcause, 32'h0);
    chk("midrst.wdata", mstatus_wdata, 32'h0);
    @(negedge clk);
    resetn = 1'b0;
    no_trap("midrst.after", 3);

    @(negedge clk);
    exc_valid = 1'b1; exc_cause = 5'd4; exc_pc = 32'h700; exc_badaddr = 32'h22;
    push("post_rst", 1'b0, 32'h700, 32'h4, 32'h22, 32'h1880, 32'h800);
    run_seq();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
